// File: rtl/btb_update_queue.sv
// Buffers resolved taken-branch (PC, target) pairs and drains one per cycle into the BTB write port.
// Duplicate PCs are coalesced so a stale target can never be written after a fresh one.
module btb_update_queue #(
  parameter int NUM_RESOLVE   = 2,
  parameter int DEPTH         = 8,
  parameter int DROP_CNT_BITS = 16,
  parameter int ADDR          = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_RESOLVE-1:0]        resolve_valid,
  input  logic [NUM_RESOLVE-1:0]        resolve_taken,
  input  logic [NUM_RESOLVE*ADDR-1:0]   resolve_branch_PC,
  input  logic [NUM_RESOLVE*ADDR-1:0]   resolve_target_PC,
  output logic                          resolving_valid,
  output logic [ADDR-1:0]               resolving_branch_PC,
  output logic [ADDR-1:0]               resolving_target_PC,
  output logic [$clog2(DEPTH):0]        queue_count,
  output logic                          queue_full,
  output logic [DROP_CNT_BITS-1:0]      drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = DROP_CNT_BITS + 1;

  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] ent_valid;
  logic [ADDR-1:0] ent_branch [DEPTH];
  logic [ADDR-1:0] ent_target [DEPTH];

  logic                   pop;
  logic [CW-1:0]          free;
  logic [NUM_RESOLVE-1:0] survive, coal_hit, alloc_hit;
  logic [PW-1:0]          coal_idx  [NUM_RESOLVE];
  logic [PW-1:0]          alloc_idx [NUM_RESOLVE];
  logic [CW-1:0]          n_alloc, n_drop;
  logic [DW-1:0]          drop_sum;

  // resolving_valid is a push-only strobe: the BTB never stalls, so the head pops whenever it is valid.
  assign pop                 = (count != '0);
  assign resolving_valid     = pop;
  assign resolving_branch_PC = ent_branch[head];
  assign resolving_target_PC = ent_target[head];
  assign queue_count         = count;
  assign queue_full          = (count == CW'(DEPTH));
  assign free                = CW'(DEPTH) - count + CW'(pop);
  assign drop_sum            = DW'(drop_count) + DW'(n_drop);

  always_comb begin
    survive   = '0;
    coal_hit  = '0;
    alloc_hit = '0;
    n_alloc   = '0;
    n_drop    = '0;
    for (int i = 0; i < NUM_RESOLVE; i++) begin
      coal_idx[i]  = '0;
      alloc_idx[i] = '0;
    end
    // A younger lane with the same PC supersedes every older one.
    for (int i = 0; i < NUM_RESOLVE; i++) begin
      survive[i] = resolve_valid[i] & resolve_taken[i];
      for (int j = i + 1; j < NUM_RESOLVE; j++) begin
        if (resolve_valid[j] && resolve_taken[j] &&
            resolve_branch_PC[j*ADDR +: ADDR] == resolve_branch_PC[i*ADDR +: ADDR])
          survive[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_RESOLVE; i++) begin
      if (survive[i]) begin
        // The head leaving this cycle is excluded so its replacement becomes a fresh entry.
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_valid[e] && ent_branch[e] == resolve_branch_PC[i*ADDR +: ADDR] &&
              !(pop && PW'(e) == head)) begin
            coal_hit[i] = 1'b1;
            coal_idx[i] = PW'(e);
          end
        end
        if (!coal_hit[i]) begin
          if (n_alloc < free) begin
            alloc_hit[i] = 1'b1;
            alloc_idx[i] = tail + n_alloc[PW-1:0];
            n_alloc      = n_alloc + CW'(1);
          end else begin
            n_drop = n_drop + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_valid  <= '0;
      drop_count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_branch[e] <= '0;
        ent_target[e] <= '0;
      end
    end else begin
      if (pop) ent_valid[head] <= 1'b0;
      // Allocation follows the head clear: when full, the freed head slot is reused this cycle.
      for (int i = 0; i < NUM_RESOLVE; i++) begin
        if (coal_hit[i]) ent_target[coal_idx[i]] <= resolve_target_PC[i*ADDR +: ADDR];
        if (alloc_hit[i]) begin
          ent_valid[alloc_idx[i]]  <= 1'b1;
          ent_branch[alloc_idx[i]] <= resolve_branch_PC[i*ADDR +: ADDR];
          ent_target[alloc_idx[i]] <= resolve_target_PC[i*ADDR +: ADDR];
        end
      end
      head       <= head + PW'(pop);
      tail       <= tail + n_alloc[PW-1:0];
      count      <= count + n_alloc - CW'(pop);
      drop_count <= drop_sum[DW-1] ? '1 : drop_sum[DROP_CNT_BITS-1:0];
    end
  end

endmodule
